key_debounce: RTL and testbench

KEY_DEBOUNCE -- requirements
Module: key_debounce

---
 rtl/key_debounce.sv | 167 ++++++++++++++++
 tb/tb_key_debounce.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
// Three-key debouncer: 2-flop sync, shared sample tick, per-key press/release FSM,
// one-cycle press pulses and a long-press pulse on the reset key.
module key_debounce #(
  parameter int unsigned TICK_DIV     = 62500,
  parameter int unsigned STABLE_TICKS = 20,
  parameter int unsigned LONG_TICKS   = 800
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_reset,
  input  logic       key_start_pause,
  input  logic       key_display_stop,
  output logic       reset_pulse,
  output logic       start_pause_pulse,
  output logic       display_stop_pulse,
  output logic       long_reset_pulse,
  output logic [2:0] key_level
);

  localparam int unsigned NKEYS = 3;
  localparam int unsigned TW    = $clog2(TICK_DIV) + 1;
  localparam int unsigned SW    = $clog2(STABLE_TICKS) + 1;
  localparam int unsigned HW    = $clog2(LONG_TICKS) + 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } state_t;

  logic [NKEYS-1:0] raw;
  logic [NKEYS-1:0] sync_a;
  logic [NKEYS-1:0] sync_b;
  logic [NKEYS-1:0] pulse;
  logic [TW-1:0]    tick_cnt;
  logic             tick;

  assign raw = {key_display_stop, key_start_pause, key_reset};

  // Synchronizers idle at 1 (keys are active-low, released = 1)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  assign tick = (tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    state_t        state;
    logic [SW-1:0] stab;
    logic [SW-1:0] stab_inc;
    logic          stab_done;
    logic          level;
    logic          press;
    logic          pressed;

    assign pressed   = ~sync_b[i];
    assign stab_inc  = stab + SW'(1);
    assign stab_done = (stab_inc >= SW'(STABLE_TICKS));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= IDLE;
        stab  <= '0;
        level <= 1'b0;
        press <= 1'b0;
      end else begin
        press <= 1'b0;
        if (tick) begin
          case (state)
            IDLE: begin
              if (pressed) begin
                state <= PRESS_CHK;
                stab  <= SW'(1);
              end
            end
            PRESS_CHK: begin
              if (!pressed) begin
                state <= IDLE;
                stab  <= '0;
              end else if (stab_done) begin
                state <= HELD;
                stab  <= '0;
                level <= 1'b1;
                press <= 1'b1;
              end else begin
                stab <= stab_inc;
              end
            end
            HELD: begin
              if (!pressed) begin
                state <= REL_CHK;
                stab  <= SW'(1);
              end
            end
            REL_CHK: begin
              // A pressed sample here is bounce: back to HELD silently
              if (pressed) begin
                state <= HELD;
                stab  <= '0;
              end else if (stab_done) begin
                state <= IDLE;
                stab  <= '0;
                level <= 1'b0;
              end else begin
                stab <= stab_inc;
              end
            end
            default: begin
              state <= IDLE;
              stab  <= '0;
            end
          endcase
        end
      end
    end

    assign key_level[i] = level;
    assign pulse[i]     = press;

    // Long-press detection only exists for the reset key
    if (i == 0) begin : g_long
      logic [HW-1:0] hold;
      logic          long_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hold   <= '0;
          long_q <= 1'b0;
        end else begin
          long_q <= 1'b0;
          if (state == IDLE) begin
            hold <= '0;
          end else if (tick && state == HELD && pressed && hold != HW'(LONG_TICKS)) begin
            hold <= hold + HW'(1);
            if (hold == HW'(LONG_TICKS - 1)) begin
              long_q <= 1'b1;
            end
          end
        end
      end

      assign long_reset_pulse = long_q;
    end
  end

  assign reset_pulse        = pulse[0];
  assign start_pause_pulse  = pulse[1];
  assign display_stop_pulse = pulse[2];

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with TICK_DIV=4, STABLE_TICKS=3, LONG_TICKS=10.
module tb_key_debounce;

  logic       clk;
  logic       rst;
  logic       key_reset;
  logic       key_start_pause;
  logic       key_display_stop;
  logic       reset_pulse;
  logic       start_pause_pulse;
  logic       display_stop_pulse;
  logic       long_reset_pulse;
  logic [2:0] key_level;

  int chk_cnt;
  int pass_cnt;

  int cyc;
  int pcnt[3];
  int pcyc[3];
  int lcnt;
  int lcyc;
  int lvl_hi[3];
  int lvl_lo[3];
  int viol;

  int p0[3];
  int l0;
  int h0[3];
  int lo0[3];

  key_debounce #(
    .TICK_DIV    (4),
    .STABLE_TICKS(3),
    .LONG_TICKS  (10)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .key_reset         (key_reset),
    .key_start_pause   (key_start_pause),
    .key_display_stop  (key_display_stop),
    .reset_pulse       (reset_pulse),
    .start_pause_pulse (start_pause_pulse),
    .display_stop_pulse(display_stop_pulse),
    .long_reset_pulse  (long_reset_pulse),
    .key_level         (key_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin
    logic [2:0] pv;
    pv  = {display_stop_pulse, start_pause_pulse, reset_pulse};
    cyc = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      if (pv[k]) begin
        pcnt[k] = pcnt[k] + 1;
        pcyc[k] = cyc;
      end
      if (key_level[k]) lvl_hi[k] = lvl_hi[k] + 1;
      else              lvl_lo[k] = lvl_lo[k] + 1;
    end
    if (long_reset_pulse) begin
      lcnt = lcnt + 1;
      lcyc = cyc;
    end
    if (rst && (pv != 3'b000 || long_reset_pulse || key_level != 3'b000)) viol = viol + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    chk_cnt = chk_cnt + 1;
    if (got == exp) pass_cnt = pass_cnt + 1;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic snap();
    for (int k = 0; k < 3; k++) begin
      p0[k]  = pcnt[k];
      h0[k]  = lvl_hi[k];
      lo0[k] = lvl_lo[k];
    end
    l0 = lcnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    cyc      = 0;
    lcnt     = 0;
    lcyc     = 0;
    viol     = 0;
    for (int k = 0; k < 3; k++) begin
      pcnt[k]   = 0;
      pcyc[k]   = 0;
      lvl_hi[k] = 0;
      lvl_lo[k] = 0;
    end

    // Reset held with every key pressed, then a fresh press on all three
    rst              = 1'b1;
    key_reset        = 1'b0;
    key_start_pause  = 1'b0;
    key_display_stop = 1'b0;
    cycles(5);
    check("rst_quiet", viol, 0);
    check("rst_level", int'(key_level), 0);
    snap();
    rst = 1'b0;
    cycles(16);
    check("post_rst_reset_pulse", pcnt[0] - p0[0], 1);
    check("post_rst_sp_pulse", pcnt[1] - p0[1], 1);
    check("post_rst_ds_pulse", pcnt[2] - p0[2], 1);
    check("post_rst_level", int'(key_level), 7);
    key_reset        = 1'b1;
    key_start_pause  = 1'b1;
    key_display_stop = 1'b1;
    cycles(30);
    check("post_rst_release_level", int'(key_level), 0);
    check("post_rst_no_long", lcnt - l0, 0);

    // Clean start_pause press of 40 cycles
    snap();
    key_start_pause = 1'b0;
    cycles(16);
    check("sp_pulse_once", pcnt[1] - p0[1], 1);
    cycles(24);
    check("sp_level_held", int'(key_level[1]), 1);
    key_start_pause = 1'b1;
    cycles(8);
    check("sp_level_release_early", int'(key_level[1]), 1);
    cycles(8);
    check("sp_level_release_late", int'(key_level[1]), 0);
    check("sp_other_pulses", (pcnt[0] - p0[0]) + (pcnt[2] - p0[2]) + (lcnt - l0), 0);
    check("sp_other_levels", (lvl_hi[0] - h0[0]) + (lvl_hi[2] - h0[2]), 0);

    // Short 5-cycle press on display_stop is rejected
    snap();
    key_display_stop = 1'b0;
    cycles(5);
    key_display_stop = 1'b1;
    cycles(30);
    check("ds_short_pulse", pcnt[2] - p0[2], 0);
    check("ds_short_level", lvl_hi[2] - h0[2], 0);

    // Long hold on key_reset: one press pulse, one long pulse 40 cycles later
    snap();
    key_reset = 1'b0;
    cycles(60);
    check("long_press_pulse", pcnt[0] - p0[0], 1);
    check("long_pulse_once", lcnt - l0, 1);
    check("long_pulse_delay", lcyc - pcyc[0], 40);
    cycles(60);
    check("long_no_repeat", lcnt - l0, 1);
    check("long_press_no_repeat", pcnt[0] - p0[0], 1);
    key_reset = 1'b1;
    cycles(30);
    check("long_release_level", int'(key_level[0]), 0);

    // Held start_pause with a 5-cycle release glitch
    snap();
    key_start_pause = 1'b0;
    cycles(20);
    for (int k = 0; k < 3; k++) lo0[k] = lvl_lo[k];
    key_start_pause = 1'b1;
    cycles(5);
    key_start_pause = 1'b0;
    cycles(40);
    check("glitch_single_pulse", pcnt[1] - p0[1], 1);
    check("glitch_level_kept", lvl_lo[1] - lo0[1], 0);
    key_start_pause = 1'b1;
    cycles(30);
    check("glitch_release_level", int'(key_level[1]), 0);

    // Reset mid-debounce, key still held afterwards
    snap();
    key_display_stop = 1'b0;
    cycles(6);
    rst = 1'b1;
    #1;
    check("mid_rst_level", int'(key_level), 0);
    check("mid_rst_pulses", int'({display_stop_pulse, start_pause_pulse, reset_pulse, long_reset_pulse}), 0);
    cycles(3);
    rst = 1'b0;
    cycles(16);
    check("mid_rst_one_pulse", pcnt[2] - p0[2], 1);
    check("mid_rst_level_after", int'(key_level), 4);
    key_display_stop = 1'b1;
    cycles(30);
    check("rst_quiet_final", viol, 0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
